tour_cmd_sched: RTL and testbench
=================================

Name: tour_cmd_sched

Overview:
Bench-side command scheduler that sequences a queued knight's tour into the robot's remote-comm link. Sits between stimulus (or a host script) and RemoteComm_e: buffers 16-bit move/calibrate commands, issues one at a time, and waits for a positive acknowledge before issuing the next. Flags bad responses, timeouts and aborts so a tour runs unattended.

Parameters:
DEPTH, 8, command FIFO entries (power of 2, >=2)
TIMEOUT, 7000000, max clk cycles from snd_cmd to final acknowledge
ACK, 8'hA5, response meaning command complete
PROG, 8'h5A, response meaning command in progress

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wr_cmd  in  1  push cmd_in into FIFO
cmd_in  in  16  command to queue ({opcode[15:12], heading[11:4], squares[3:0]})
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
go  in  1  start draining FIFO (sampled only in IDLE)
abort  in  1  stop sequencing immediately
clr_err  in  1  leave ERR, flush FIFO
cmd  out  16  command to RemoteComm_e
snd_cmd  out  1  one-cycle send strobe to RemoteComm_e
cmd_snt  in  1  RemoteComm_e finished transmitting
resp_rdy  in  1  response byte valid (one-cycle)
resp  in  8  response byte
busy  out  1  state not IDLE and not ERR
done  out  1  one-cycle pulse when FIFO drained with all ACKs
err  out  1  high while in ERR
err_code  out  2  01 bad resp, 10 timeout, 11 abort; 00 otherwise
cmds_done  out  8  count of ACKed commands since reset, wraps 255->0

Behaviour:
- Reset (rst high at posedge): state IDLE, FIFO empty, cmd=16'h0000, snd_cmd=0, done=0, err=0, err_code=00, cmds_done=0, timeout counter 0.
- FIFO: pointers log2(DEPTH)+1 bits; push when full ignored (no overwrite); push and pop same cycle allowed, count unchanged; push while empty and pop impossible same cycle (pop only when !empty).
- States: IDLE, SEND, WAIT_SNT, WAIT_RESP, ERR.
- IDLE: go & !empty -> SEND. go while empty: no action, no done pulse. abort in IDLE flushes FIFO, stays IDLE, no err.
- SEND (one cycle): cmd <= FIFO head, pop, snd_cmd=1 (registered, high exactly one cycle, cmd valid same cycle), timeout counter cleared -> WAIT_SNT. Latency go->snd_cmd: snd_cmd high in cycle after go sampled.
- cmd holds last issued value until next SEND; never changes mid-transaction.
- WAIT_SNT: cmd_snt -> WAIT_RESP.
- WAIT_RESP on resp_rdy: resp==ACK -> cmds_done+1; if FIFO empty -> done pulse, IDLE; else -> SEND (back-to-back, no gap beyond SEND cycle). resp==PROG -> stay, timeout counter cleared. Other value -> ERR, err_code=01.
- Timeout counter increments every cycle in WAIT_SNT/WAIT_RESP; reaching TIMEOUT-1 without ACK -> ERR, err_code=10. ACK on the same cycle as expiry wins (treated as ACK).
- abort in SEND/WAIT_SNT/WAIT_RESP -> ERR, err_code=11; abort takes priority over simultaneous resp_rdy. No further snd_cmd after abort.
- Commands pushed during sequencing are appended and executed in the same run.
- ERR: err=1, busy=0, FIFO frozen (pushes ignored); clr_err -> flush FIFO, err_code=00, IDLE. cmds_done retained.
- rst mid-transaction: return to reset values next cycle regardless of state; in-flight response discarded.

Test Plan:
- Push 16'h2000, go; drive cmd_snt then resp_rdy with 8'hA5 -> exactly one snd_cmd with cmd=16'h2000, done pulse one cycle after ACK, cmds_done=1, busy=0.
- Push 16'h2000, 16'h4022, 16'h43F1, go; ACK each -> three snd_cmd strobes in push order, second SEND one cycle after first ACK, single done after third ACK, cmds_done=3.
- Push 16'h4022, go; respond 8'h5A twice then 8'hA5 with TIMEOUT=100 and 60-cycle gaps -> no timeout, done asserted, err=0.
- Push two commands, go; respond 8'h3C -> err=1, err_code=01, second command never sent; clr_err -> empty=1, err=0, state IDLE.
- TIMEOUT=50, push one command, go, never respond -> err_code=10 exactly 50 cycles after snd_cmd; abort during WAIT_RESP of a new run with same-cycle resp_rdy=8'hA5 -> err_code=11, cmds_done unchanged.
- Push DEPTH+1 commands while IDLE -> full=1 after DEPTH, extra dropped; go with ACKs -> exactly DEPTH snd_cmd strobes; rst mid-run -> snd_cmd=0, empty=1, cmds_done=0.

Source files
------------

// File: rtl/tour_cmd_sched.sv
// Purpose: queues 16-bit tour commands and issues them one at a time to RemoteComm_e, waiting for ACK.
// Latency: snd_cmd rises the cycle after go is sampled; next command issues the cycle after an ACK.
// Backpressure: pushes dropped when full or in ERR; progress gated on cmd_snt/resp_rdy with a timeout.
module tour_cmd_sched #(
    parameter int         DEPTH   = 8,
    parameter int         TIMEOUT = 7000000,
    parameter logic [7:0] ACK     = 8'hA5,
    parameter logic [7:0] PROG    = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_cmd,
    input  logic [15:0] cmd_in,
    output logic        full,
    output logic        empty,
    input  logic        go,
    input  logic        abort,
    input  logic        clr_err,
    output logic [15:0] cmd,
    output logic        snd_cmd,
    input  logic        cmd_snt,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  cmds_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
    localparam logic [TW-1:0] TMR_ONE = TW'(1);
    // Counter value on which the deadline edge fires; counting starts at the issuing edge.
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_SNT, WAIT_RESP, ERR} state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW:0]   wp;
    logic [AW:0]   rp;
    logic [15:0]   fifo_head;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic          do_push;
    logic [TW-1:0] tmr;
    logic          resp_ack;
    logic          resp_prog;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty     = (wp == rp);
    assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign fifo_head = mem[rp[AW-1:0]];
    // A pop in the same cycle frees the slot, so a push into a full FIFO is only taken then.
    assign do_push   = fifo_push && (!full || fifo_pop);

    assign resp_ack  = resp_rdy && (resp == ACK);
    assign resp_prog = resp_rdy && (resp == PROG);
    assign busy      = (state != IDLE) && (state != ERR);
    assign err       = (state == ERR);

    // The FIFO is frozen while in ERR so the failing tour can be inspected before clr_err.
    assign fifo_push = wr_cmd && (state != ERR);

    // Pop on the edge that enters SEND (the head is latched into cmd at that edge); flush on abort/clear.
    always_comb begin
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        case (state)
            IDLE: begin
                if (abort)
                    fifo_flush = 1'b1;
                else if (go && !empty)
                    fifo_pop = 1'b1;
            end
            WAIT_RESP: begin
                if (!abort && resp_ack && !empty)
                    fifo_pop = 1'b1;
            end
            ERR: begin
                if (clr_err)
                    fifo_flush = 1'b1;
            end
            default: ;
        endcase
    end

    // FIFO pointers; flush wins over a simultaneous push.
    always_ff @(posedge clk) begin
        if (rst || fifo_flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push)
                wp <= wp + PTR_ONE;
            if (fifo_pop)
                rp <= rp + PTR_ONE;
        end
    end

    // FIFO storage, no reset needed since the pointers guard every read.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp[AW-1:0]] <= cmd_in;
    end

    // Sequencer: issue, wait for transmit, wait for ACK; outputs registered on the transition edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd       <= 16'h0000;
            snd_cmd   <= 1'b0;
            done      <= 1'b0;
            err_code  <= 2'b00;
            cmds_done <= 8'd0;
            tmr       <= '0;
        end else begin
            snd_cmd <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!abort && go && !empty) begin
                        state   <= SEND;
                        cmd     <= fifo_head;
                        snd_cmd <= 1'b1;
                        tmr     <= '0;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state    <= ERR;
                        err_code <= 2'b11;
                    end else begin
                        state <= WAIT_SNT;
                        tmr   <= tmr + TMR_ONE;
                    end
                end
                WAIT_SNT: begin
                    if (abort) begin
                        state    <= ERR;
                        err_code <= 2'b11;
                    end else if (tmr == TMR_LAST) begin
                        state    <= ERR;
                        err_code <= 2'b10;
                    end else begin
                        tmr <= tmr + TMR_ONE;
                        if (cmd_snt)
                            state <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    // Abort beats any response; an ACK beats a deadline expiring on the same edge.
                    if (abort) begin
                        state    <= ERR;
                        err_code <= 2'b11;
                    end else if (resp_ack) begin
                        cmds_done <= cmds_done + 8'd1;
                        if (empty) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state   <= SEND;
                            cmd     <= fifo_head;
                            snd_cmd <= 1'b1;
                            tmr     <= '0;
                        end
                    end else if (resp_prog) begin
                        tmr <= '0;
                    end else if (resp_rdy) begin
                        state    <= ERR;
                        err_code <= 2'b01;
                    end else if (tmr == TMR_LAST) begin
                        state    <= ERR;
                        err_code <= 2'b10;
                    end else begin
                        tmr <= tmr + TMR_ONE;
                    end
                end
                ERR: begin
                    if (clr_err) begin
                        state    <= IDLE;
                        err_code <= 2'b00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tour_cmd_sched.sv
// Purpose: checks tour_cmd_sched against a queue-based transaction model plus directed literals.
// Latency: model expects snd_cmd the cycle after go/ACK and a timeout exactly TMO cycles after issue.
// Backpressure: drives cmd_snt/resp pulses itself; every wait is bounded.
module tb_tour_cmd_sched;

    localparam int         DEPTH = 8;
    localparam int         TMO   = 100;
    localparam logic [7:0] ACKB  = 8'hA5;
    localparam logic [7:0] PROGB = 8'h5A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_cmd = 1'b0;
    logic [15:0] cmd_in = 16'h0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic        clr_err = 1'b0;
    logic        cmd_snt = 1'b0;
    logic        resp_rdy = 1'b0;
    logic [7:0]  resp = 8'h0;
    logic        full, empty, snd_cmd, busy, done, err;
    logic [15:0] cmd;
    logic [1:0]  err_code;
    logic [7:0]  cmds_done;

    always #5 clk = ~clk;

    tour_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT(TMO), .ACK(ACKB), .PROG(PROGB)) dut (
        .clk(clk), .rst(rst), .wr_cmd(wr_cmd), .cmd_in(cmd_in), .full(full), .empty(empty),
        .go(go), .abort(abort), .clr_err(clr_err), .cmd(cmd), .snd_cmd(snd_cmd),
        .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .cmds_done(cmds_done)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: pending commands, run/error status, ACK count, deadline reference.
    logic [15:0] q[$];
    logic [15:0] m_cmd = 16'h0;
    logic [1:0]  m_code = 2'b00;
    int          m_acks = 0;
    int          ncyc = 0;
    int          m_ref = 0;
    int          snd_count = 0;
    bit          m_busy = 0, m_err = 0, m_done = 0, m_snd_exp = 0, m_tmo_on = 0, m_prog = 0;
    bit          started = 0;

    task automatic model_reset();
        q.delete();
        m_cmd = 16'h0; m_code = 2'b00; m_acks = 0;
        m_busy = 0; m_err = 0; m_done = 0; m_snd_exp = 0; m_tmo_on = 0; m_prog = 0;
    endtask

    // Advance one clock, then apply the driven inputs' effect to the model and drop pulse inputs.
    task automatic tick();
        bit acc;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            acc = wr_cmd && !m_err && !(abort && !m_busy) && (q.size() < DEPTH);
            if (m_err) begin
                if (clr_err) begin m_err = 0; m_code = 2'b00; q.delete(); end
            end else if (abort) begin
                if (m_busy) begin m_err = 1; m_code = 2'b11; m_busy = 0; m_tmo_on = 0; end
                else q.delete();
            end else if (!m_busy) begin
                if (go && q.size() > 0) begin m_busy = 1; m_snd_exp = 1; end
            end else if (resp_rdy) begin
                if (resp == ACKB) begin
                    m_acks++;
                    m_tmo_on = 0;
                    if (q.size() == 0) begin m_busy = 0; m_done = 1; end
                    else m_snd_exp = 1;
                end else if (resp == PROGB) begin
                    m_prog = 1;
                end else begin
                    m_err = 1; m_code = 2'b01; m_busy = 0; m_tmo_on = 0;
                end
            end
            if (acc) q.push_back(cmd_in);
        end
        rst = 0; wr_cmd = 0; go = 0; abort = 0; clr_err = 0; cmd_snt = 0; resp_rdy = 0;
    endtask

    // Per-cycle comparison of every DUT output against the model, sampled mid-cycle.
    always @(negedge clk) begin
        bit exp_snd;
        if (started) begin
            ncyc++;
            if (snd_cmd === 1'b1) snd_count++;
            if (m_prog) begin m_ref = ncyc; m_prog = 0; end
            exp_snd = m_snd_exp;
            if (m_snd_exp) begin
                if (q.size() > 0) m_cmd = q.pop_front();
                else check("model_q_nonempty", 0, 1);
                m_ref = ncyc; m_tmo_on = 1; m_snd_exp = 0;
            end
            if (m_tmo_on && (ncyc - m_ref == TMO)) begin
                m_err = 1; m_code = 2'b10; m_busy = 0; m_tmo_on = 0;
            end
            check("cyc_snd_cmd", snd_cmd, exp_snd);
            check("cyc_cmd", cmd, m_cmd);
            check("cyc_empty", empty, q.size() == 0);
            check("cyc_full", full, q.size() == DEPTH);
            check("cyc_busy", busy, m_busy);
            check("cyc_err", err, m_err);
            check("cyc_err_code", err_code, m_code);
            check("cyc_done", done, m_done);
            check("cyc_cmds_done", cmds_done, 8'(m_acks));
            m_done = 0;
        end
    end

    task automatic push(input logic [15:0] c);
        wr_cmd = 1; cmd_in = c;
        tick();
    endtask

    task automatic wait_snd(output int n);
        n = 0;
        while (snd_cmd !== 1'b1 && n < 20) begin tick(); n++; end
        check("snd_cmd_seen", snd_cmd, 1);
    endtask

    // Serve one issued command: transmit-complete, optional PROG responses, then a final response.
    task automatic serve(input logic [15:0] exp_cmd, input int nprog, input int gap,
                         input logic [7:0] last, output int lat);
        wait_snd(lat);
        check("issued_cmd", cmd, exp_cmd);
        tick();
        cmd_snt = 1; tick();
        repeat (nprog) begin
            repeat (gap) tick();
            resp_rdy = 1; resp = PROGB; tick();
        end
        repeat (gap) tick();
        resp_rdy = 1; resp = last; tick();
    endtask

    initial begin
        int lat;
        int n;
        int snd_base;

        rst = 1; tick();
        started = 1;
        check("rst_cmd", cmd, 16'h0000);
        check("rst_snd_cmd", snd_cmd, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 2'b00);
        check("rst_cmds_done", cmds_done, 8'd0);
        check("rst_done", done, 0);

        // go on an empty FIFO does nothing
        go = 1; tick();
        check("go_empty_busy", busy, 0);
        tick();

        // single command
        push(16'h2000);
        go = 1; tick();
        serve(16'h2000, 0, 0, ACKB, lat);
        check("t1_go_latency", lat, 0);
        check("t1_done", done, 1);
        check("t1_cmds_done", cmds_done, 8'd1);
        check("t1_busy", busy, 0);
        tick();
        check("t1_done_one_cycle", done, 0);

        // three commands back-to-back in push order
        push(16'h2000); push(16'h4022); push(16'h43F1);
        go = 1; tick();
        serve(16'h2000, 0, 0, ACKB, lat);
        check("t2_no_early_done", done, 0);
        serve(16'h4022, 0, 0, ACKB, lat);
        check("t2_b2b_second", lat, 0);
        serve(16'h43F1, 0, 0, ACKB, lat);
        check("t2_b2b_third", lat, 0);
        check("t2_done", done, 1);
        check("t2_cmds_done", cmds_done, 8'd4);
        tick();

        // PROG responses keep restarting the deadline
        push(16'h4022);
        go = 1; tick();
        serve(16'h4022, 2, 60, ACKB, lat);
        check("t3_done", done, 1);
        check("t3_err", err, 0);
        check("t3_cmds_done", cmds_done, 8'd5);
        tick();

        // bad response stops the run; FIFO frozen until clr_err
        push(16'h1111); push(16'h2222);
        go = 1; tick();
        serve(16'h1111, 0, 0, 8'h3C, lat);
        check("t4_err", err, 1);
        check("t4_err_code", err_code, 2'b01);
        repeat (5) tick();
        check("t4_fifo_held", empty, 0);
        push(16'h3333);
        clr_err = 1; tick();
        check("t4_clr_empty", empty, 1);
        check("t4_clr_err", err, 0);
        check("t4_clr_code", err_code, 2'b00);
        check("t4_clr_busy", busy, 0);

        // no response at all: timeout exactly TMO cycles after the send strobe
        push(16'h5555);
        go = 1; tick();
        wait_snd(lat);
        tick();
        cmd_snt = 1; tick();
        n = 2;
        while (err !== 1'b1 && n < 3 * TMO) begin tick(); n++; end
        check("t5_timeout_cycles", n, TMO);
        check("t5_timeout_code", err_code, 2'b10);
        clr_err = 1; tick();

        // abort beats a simultaneous ACK
        push(16'h6666);
        go = 1; tick();
        wait_snd(lat);
        tick();
        cmd_snt = 1; tick();
        tick();
        abort = 1; resp_rdy = 1; resp = ACKB; tick();
        check("t5_abort_err", err, 1);
        check("t5_abort_code", err_code, 2'b11);
        check("t5_abort_cmds_done", cmds_done, 8'd5);
        clr_err = 1; tick();

        // abort while idle just flushes
        push(16'h7777); push(16'h8888);
        abort = 1; tick();
        check("idle_abort_empty", empty, 1);
        check("idle_abort_err", err, 0);

        // overfill: DEPTH accepted, extra dropped
        for (int i = 0; i <= DEPTH; i++) begin
            push(16'h1000 + 16'(i));
            if (i == DEPTH - 1) check("t6_full_at_depth", full, 1);
        end
        check("t6_full_after_extra", full, 1);
        snd_base = snd_count;
        go = 1; tick();
        for (int i = 0; i < DEPTH; i++) serve(16'h1000 + 16'(i), 0, 0, ACKB, lat);
        check("t6_done", done, 1);
        repeat (5) tick();
        check("t6_strobes", snd_count - snd_base, DEPTH);
        check("t6_cmds_done", cmds_done, 8'd13);

        // reset in the middle of a run
        push(16'hA001); push(16'hA002); push(16'hA003);
        go = 1; tick();
        wait_snd(lat);
        rst = 1; tick();
        check("t6_rst_snd_cmd", snd_cmd, 0);
        check("t6_rst_empty", empty, 1);
        check("t6_rst_cmds_done", cmds_done, 8'd0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cmd", cmd, 16'h0000);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
